pc_fetch_stage: RTL and testbench
=================================

Name: pc_fetch_stage

Overview:
- Program-counter register and instruction-fetch stage. It sits directly upstream of the next-PC logic.
- Holds CurrentPC and fetches the instruction at CurrentPC over a request/ready handshake to instruction memory.
- Delivers the fetched instruction into an IF/ID pipeline register.
- Loads NextPC, produced by the downstream next-PC logic, once each fetched instruction is handed off.

Parameters:
- RESET_PC, 64'h0, value loaded into CurrentPC on reset.
- NOP_INSTR, 32'hD503201F, encoding placed in IF_ID_Instr for bubbles and after reset.
- MAX_WAIT, 16, consecutive un-ready request cycles that trigger a fetch fault (legal range 2..255).

Ports:
- CLK input 1: clock, rising-edge.
- Reset input 1: synchronous, active-high reset.
- NextPC input 64: next PC from next-PC logic, sampled at handoff or flush.
- Stall input 1: downstream stage cannot accept a new IF/ID entry.
- Flush input 1: redirect; discard fetched/buffered instruction and load NextPC.
- IMemReady input 1: memory completes the request this cycle; IMemData valid this cycle.
- IMemData input 32: instruction word.
- IMemReq output 1: fetch request.
- IMemAddr output 64: fetch address, always equal to CurrentPC.
- CurrentPC output 64: PC register.
- PCPlus4 output 64: CurrentPC+4, modulo 2^64.
- IF_ID_PC output 64: PC of the instruction in IF/ID.
- IF_ID_Instr output 32: instruction in IF/ID.
- IF_ID_Valid output 1: IF/ID holds a real instruction.
- FetchFault output 1: sticky fault flag.

Behaviour:
- Reset is synchronous and active-high and overrides everything. At the reset edge:
  - CurrentPC=RESET_PC, IF_ID_PC=0, IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0, FetchFault=0.
  - Buffer cleared, WaitCount=0, state=REQ.
- While Reset=1, IMemReq=0.
- States:
  - REQ: IMemReq=1 when CurrentPC[1:0]==0. If CurrentPC[1:0]!=0, IMemReq=0 and the next state is FAULT, which sets FetchFault.
  - HELD: the instruction has been captured in an internal buffer. IMemReq=0. The stage waits for Stall=0.
  - FAULT: IMemReq=0. FetchFault=1. All other registers hold. Flush is ignored. Only Reset exits.
- Handoff (REQ, IMemReady=1, Stall=0, Flush=0):
  - IF_ID_PC<=CurrentPC, IF_ID_Instr<=IMemData, IF_ID_Valid<=1.
  - CurrentPC<=NextPC, WaitCount<=0. Stay in REQ.
  - A new request is issued the next cycle, so throughput is 1 instruction/cycle with a zero-wait memory.
- Completion under stall (REQ, IMemReady=1, Stall=1, Flush=0): buffer<=IMemData, go to HELD. IF/ID and CurrentPC hold.
- HELD with Stall=0, Flush=0: IF/ID<=(CurrentPC, buffer, valid=1), CurrentPC<=NextPC, go to REQ.
- REQ with IMemReady=0:
  - WaitCount increments.
  - If WaitCount==MAX_WAIT-1, go to FAULT instead. The fault therefore sets on the MAX_WAIT-th consecutive un-ready cycle.
- Bubble insertion: any non-FAULT cycle with Stall=0 and no handoff loads IF_ID_Valid<=0, IF_ID_Instr<=NOP_INSTR. IF_ID_PC holds.
- Stall=1 without flush: IF/ID holds.
- Flush=1, in any state except FAULT, wins over Stall and IMemReady:
  - CurrentPC<=NextPC, IF_ID_Valid<=0, IF_ID_Instr<=NOP_INSTR.
  - Buffer discarded, WaitCount<=0, state<=REQ.
  - A completion in the same cycle is dropped.
- IMemReq may fall without completion on flush or fault. Memory must treat ready as meaningful only while IMemReq=1.
- NextPC is sampled only at handoff or flush edges; its value at other times is ignored.
- PCPlus4 is combinational. CurrentPC=64'hFFFF_FFFF_FFFF_FFFC gives PCPlus4=0.

Test Plan:
- Zero-wait stream: Reset, then IMemReady=1, NextPC=PCPlus4, IMemData=0x8B020020 at PC 0, 0x8B030041 at PC 4, 0x8B040062 at PC 8 → IF/ID receives (0,0x8B020020),(4,0x8B030041),(8,0x8B040062) on consecutive cycles with IF_ID_Valid=1; IMemAddr sequence 0,4,8.
- Wait states: IMemReady low 3 cycles then high at PC 0x40 → IMemReq=1 all 4 cycles, IF/ID valid bubbles for 3 cycles, then (0x40, data); FetchFault stays 0.
- Stall capture: completion at PC 0x10 while Stall=1 for 2 further cycles → IMemReq=0 in HELD, IF/ID unchanged; on Stall=0, IF/ID=(0x10,data) and CurrentPC=NextPC.
- Flush priority: Flush=1, Stall=1, IMemReady=1 same cycle, NextPC=0x200 → IF_ID_Valid=0, IF_ID_Instr=NOP_INSTR, CurrentPC=0x200, next IMemAddr=0x200, dropped data never appears.
- Timeout: IMemReady held 0 with MAX_WAIT=16 → FetchFault=1 after the 16th un-ready cycle, IMemReq=0; a later Flush is ignored; Reset clears it and restarts at RESET_PC.
- Misalignment/wrap: flush to NextPC=0x102 → FAULT next cycle, no request issued. Separately, CurrentPC=0xFFFF_FFFF_FFFF_FFFC → PCPlus4=0.

Source files
------------

// File: rtl/pc_fetch_stage.sv
// Program-counter register and instruction-fetch stage: fetches at CurrentPC over a
// request/ready handshake and hands instructions into the IF/ID pipeline register.
module pc_fetch_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'hD503201F,
    parameter int unsigned MAX_WAIT  = 16
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [63:0] NextPC,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic        IMemReq,
    output logic [63:0] IMemAddr,
    output logic [63:0] CurrentPC,
    output logic [63:0] PCPlus4,
    output logic [63:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instr,
    output logic        IF_ID_Valid,
    output logic        FetchFault
);

    typedef enum logic [1:0] {S_REQ, S_HELD, S_FAULT} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_next;
    logic [31:0] instr_buf;
    logic [7:0]  wait_cnt;
    logic        aligned;
    logic        complete;
    logic        handoff;
    logic        timeout;

    assign aligned  = (CurrentPC[1:0] == 2'b00);
    assign complete = (state == S_REQ) && aligned && IMemReady;
    assign handoff  = !Flush && !Stall && (complete || (state == S_HELD));
    assign timeout  = (state == S_REQ) && aligned && !IMemReady && (wait_cnt == WAIT_LAST);

    assign IMemAddr = CurrentPC;
    assign PCPlus4  = CurrentPC + 64'd4;

    always_ff @(posedge CLK) begin
        if (Reset) state <= S_REQ;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_REQ: begin
                if (Flush)           state_next = S_REQ;
                else if (!aligned)   state_next = S_FAULT;
                else if (IMemReady)  state_next = Stall ? S_HELD : S_REQ;
                else if (timeout)    state_next = S_FAULT;
            end
            S_HELD: begin
                if (Flush || !Stall) state_next = S_REQ;
            end
            S_FAULT: state_next = S_FAULT;
            default: state_next = S_REQ;
        endcase
    end

    always_comb begin
        IMemReq    = !Reset && (state == S_REQ) && aligned;
        FetchFault = (state == S_FAULT);
    end

    // PC, IF/ID register, capture buffer and wait counter; everything freezes in FAULT
    always_ff @(posedge CLK) begin
        if (Reset) begin
            CurrentPC   <= RESET_PC;
            IF_ID_PC    <= 64'h0;
            IF_ID_Instr <= NOP_INSTR;
            IF_ID_Valid <= 1'b0;
            instr_buf   <= 32'h0;
            wait_cnt    <= 8'd0;
        end else if (state != S_FAULT) begin
            if (Flush) begin
                CurrentPC   <= NextPC;
                IF_ID_Valid <= 1'b0;
                IF_ID_Instr <= NOP_INSTR;
                instr_buf   <= 32'h0;
                wait_cnt    <= 8'd0;
            end else if (handoff) begin
                IF_ID_PC    <= CurrentPC;
                IF_ID_Instr <= (state == S_HELD) ? instr_buf : IMemData;
                IF_ID_Valid <= 1'b1;
                CurrentPC   <= NextPC;
                wait_cnt    <= 8'd0;
            end else begin
                if (!Stall) begin
                    IF_ID_Valid <= 1'b0;
                    IF_ID_Instr <= NOP_INSTR;
                end
                if (complete) begin
                    instr_buf <= IMemData;
                    wait_cnt  <= 8'd0;
                end else if ((state == S_REQ) && aligned) begin
                    wait_cnt  <= wait_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed, table-driven bench for pc_fetch_stage: each row drives one cycle of inputs
// and lists the outputs expected during that cycle, before its rising edge.
module tb_pc_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [63:0] NextPC;
    logic        Stall;
    logic        Flush;
    logic        IMemReady;
    logic [31:0] IMemData;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic [63:0] CurrentPC;
    logic [63:0] PCPlus4;
    logic [63:0] IF_ID_PC;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic        FetchFault;

    int tests = 0;
    int fails = 0;

    pc_fetch_stage #(
        .RESET_PC (64'h0),
        .NOP_INSTR(NOP),
        .MAX_WAIT (16)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .NextPC     (NextPC),
        .Stall      (Stall),
        .Flush      (Flush),
        .IMemReady  (IMemReady),
        .IMemData   (IMemData),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .CurrentPC  (CurrentPC),
        .PCPlus4    (PCPlus4),
        .IF_ID_PC   (IF_ID_PC),
        .IF_ID_Instr(IF_ID_Instr),
        .IF_ID_Valid(IF_ID_Valid),
        .FetchFault (FetchFault)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [63:0] npc;
        logic        stall;
        logic        flush;
        logic        rdy;
        logic [31:0] data;
        logic        e_req;
        logic [63:0] e_pc;
        logic [63:0] e_ifpc;
        logic [31:0] e_instr;
        logic        e_v;
        logic        e_f;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [63:0] npc, input logic stall,
                       input logic flush, input logic rdy, input logic [31:0] data,
                       input logic e_req, input logic [63:0] e_pc, input logic [63:0] e_ifpc,
                       input logic [31:0] e_instr, input logic e_v, input logic e_f);
        vec_t v;
        v.rst = rst; v.npc = npc; v.stall = stall; v.flush = flush; v.rdy = rdy; v.data = data;
        v.e_req = e_req; v.e_pc = e_pc; v.e_ifpc = e_ifpc; v.e_instr = e_instr;
        v.e_v = e_v; v.e_f = e_f;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, got, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [63:0] npc, input logic stall,
                         input logic flush, input logic rdy, input logic [31:0] data);
        Reset = rst; NextPC = npc; Stall = stall; Flush = flush; IMemReady = rdy; IMemData = data;
    endtask

    initial begin
        // Reset rows, zero-wait stream, wait states, stall capture, flush priority
        add(1, 64'h0,   0, 0, 0, 32'h0,        0, 64'h0,   64'h0,   NOP,          0, 0);
        add(0, 64'h4,   0, 0, 1, 32'h8B020020, 1, 64'h0,   64'h0,   NOP,          0, 0);
        add(0, 64'h8,   0, 0, 1, 32'h8B030041, 1, 64'h4,   64'h0,   32'h8B020020, 1, 0);
        add(0, 64'h40,  0, 0, 1, 32'h8B040062, 1, 64'h8,   64'h4,   32'h8B030041, 1, 0);
        add(0, 64'h44,  0, 0, 0, 32'h0,        1, 64'h40,  64'h8,   32'h8B040062, 1, 0);
        add(0, 64'h44,  0, 0, 0, 32'h0,        1, 64'h40,  64'h8,   NOP,          0, 0);
        add(0, 64'h44,  0, 0, 0, 32'h0,        1, 64'h40,  64'h8,   NOP,          0, 0);
        add(0, 64'h10,  0, 0, 1, 32'hAAAA0001, 1, 64'h40,  64'h8,   NOP,          0, 0);
        add(0, 64'h999, 1, 0, 1, 32'hBBBB0002, 1, 64'h10,  64'h40,  32'hAAAA0001, 1, 0);
        add(0, 64'h999, 1, 0, 1, 32'hCCCC0003, 0, 64'h10,  64'h40,  32'hAAAA0001, 1, 0);
        add(0, 64'h999, 1, 0, 0, 32'h0,        0, 64'h10,  64'h40,  32'hAAAA0001, 1, 0);
        add(0, 64'h20,  0, 0, 0, 32'h0,        0, 64'h10,  64'h40,  32'hAAAA0001, 1, 0);
        add(0, 64'h200, 1, 1, 1, 32'hDDDD0004, 1, 64'h20,  64'h10,  32'hBBBB0002, 1, 0);
        add(0, 64'h204, 0, 0, 1, 32'hEEEE0005, 1, 64'h200, 64'h10,  NOP,          0, 0);
        add(0, 64'h0,   0, 0, 0, 32'h0,        1, 64'h204, 64'h200, 32'hEEEE0005, 1, 0);
        // Misaligned redirect faults without issuing a request; flush then ignored
        add(0, 64'h102, 0, 1, 0, 32'h0,        1, 64'h204, 64'h200, NOP,          0, 0);
        add(0, 64'h300, 0, 0, 1, 32'hFFFF0006, 0, 64'h102, 64'h200, NOP,          0, 0);
        add(0, 64'h400, 0, 1, 0, 32'h0,        0, 64'h102, 64'h200, NOP,          0, 1);
        add(0, 64'h0,   0, 0, 0, 32'h0,        0, 64'h102, 64'h200, NOP,          0, 1);
        add(1, 64'h0,   0, 0, 0, 32'h0,        0, 64'h102, 64'h200, NOP,          0, 1);
        // Timeout: 16 un-ready cycles, fault appears on the cycle after the 16th
        for (int k = 0; k < 16; k++)
            add(0, 64'h0, 0, 0, 0, 32'h0,      1, 64'h0,   64'h0,   NOP,          0, 0);
        add(0, 64'h80,  0, 1, 1, 32'h0,        0, 64'h0,   64'h0,   NOP,          0, 1);
        add(0, 64'h0,   0, 0, 0, 32'h0,        0, 64'h0,   64'h0,   NOP,          0, 1);
        add(1, 64'h0,   0, 0, 0, 32'h0,        0, 64'h0,   64'h0,   NOP,          0, 1);
        add(0, 64'h0,   0, 0, 0, 32'h0,        1, 64'h0,   64'h0,   NOP,          0, 0);

        drive(1, 64'h0, 0, 0, 0, 32'h0);
        @(posedge CLK); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].npc, vecs[i].stall, vecs[i].flush, vecs[i].rdy, vecs[i].data);
            @(negedge CLK);
            check("IMemReq",     i, 64'(IMemReq),     64'(vecs[i].e_req));
            check("CurrentPC",   i, CurrentPC,        vecs[i].e_pc);
            check("IMemAddr",    i, IMemAddr,         vecs[i].e_pc);
            check("PCPlus4",     i, PCPlus4,          vecs[i].e_pc + 64'd4);
            check("IF_ID_PC",    i, IF_ID_PC,         vecs[i].e_ifpc);
            check("IF_ID_Instr", i, 64'(IF_ID_Instr), 64'(vecs[i].e_instr));
            check("IF_ID_Valid", i, 64'(IF_ID_Valid), 64'(vecs[i].e_v));
            check("FetchFault",  i, 64'(FetchFault),  64'(vecs[i].e_f));
            @(posedge CLK); #1;
        end

        // PC wrap: redirect to the top word, then hand off with NextPC = 0
        drive(0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 1, 0, 32'h0);
        @(posedge CLK); #1;
        drive(0, 64'h0, 0, 0, 0, 32'h0);
        @(negedge CLK);
        check("wrap_pc",    100, CurrentPC, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_plus4", 100, PCPlus4,   64'h0);
        check("wrap_req",   100, 64'(IMemReq), 64'd1);
        @(posedge CLK); #1;
        drive(0, 64'h0, 0, 0, 1, 32'h12345678);
        @(posedge CLK); #1;
        drive(0, 64'h0, 0, 0, 0, 32'h0);
        @(negedge CLK);
        check("wrap_next_pc", 101, CurrentPC,          64'h0);
        check("wrap_if_pc",   101, IF_ID_PC,           64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_if_ins",  101, 64'(IF_ID_Instr),   64'h12345678);
        check("wrap_if_v",    101, 64'(IF_ID_Valid),   64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
